// File: rtl/au_down_counter.sv
// au_down_counter: loadable, pausable down-counter built around one AU_dec.
// A start value is taken over a valid/ready handshake and counted down to zero,
// one step per enabled cycle; done pulses for one cycle when zero is reached.
// Optional build macro AU_DOWN_COUNTER_RELOAD_EN adds the auto_reload input:
// the count restarts from the last loaded value instead of finishing.
// AU_dec (decrement-by-one datapath) lives in this file so the block is
// self-contained; ARCH selects its implementation:
//   0 (and any unknown value): plain subtract
//   1: explicit ripple-borrow chain
//   2: add of the all-ones word (two's complement -1)

module AU_dec #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if (ARCH == 1) begin : g_ripple
            // borrow[i] is set when every bit below i is zero
            logic [WIDTH-1:0] borrow;
            assign borrow[0] = 1'b1;
            for (genvar i = 1; i < WIDTH; i++) begin : g_bit
                assign borrow[i] = borrow[i-1] & ~a[i-1];
            end
            assign y = a ^ borrow;
        end else if (ARCH == 2) begin : g_addones
            assign y = a + {WIDTH{1'b1}};
        end else begin : g_sub
            assign y = a - ONE;
        end
    endgenerate

endmodule

module au_down_counter #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_value,
    input  logic             en,
    input  logic             abort,
`ifdef AU_DOWN_COUNTER_RELOAD_EN
    input  logic             auto_reload,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] dec;
    logic             load;

`ifdef AU_DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_val;
    logic             reload_flag;
    logic             reload_flag_nxt;
`endif

    // Decrement datapath; its result is only used while cnt >= 2
    AU_dec #(
        .WIDTH(WIDTH),
        .ARCH (ARCH)
    ) u_dec (
        .a(cnt),
        .y(dec)
    );

    assign ld_ready = (state != S_RUN) && !abort;
    assign load     = ld_valid && ld_ready;
    assign busy     = (state == S_RUN);
`ifdef AU_DOWN_COUNTER_RELOAD_EN
    assign done     = (state == S_DONE) || reload_flag;
`else
    assign done     = (state == S_DONE);
`endif

    // Next-state and next-count selection
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
        reload_flag_nxt = 1'b0;
`endif
        case (state)
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (en) begin
                    if (cnt == ONE) begin
                        // Last step forced to zero; never wraps below zero
                        cnt_nxt = '0;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
                        if (auto_reload) begin
                            reload_flag_nxt = 1'b1;
                        end else begin
                            state_nxt = S_DONE;
                        end
`else
                        state_nxt = S_DONE;
`endif
                    end
`ifdef AU_DOWN_COUNTER_RELOAD_EN
                    else if (cnt == '0) begin
                        // Zero in RUN only occurs in the periodic reload slot
                        cnt_nxt = reload_val;
                    end
`endif
                    else begin
                        cnt_nxt = dec;
                    end
                end
            end
            default: begin
                // IDLE and DONE both accept a load; DONE otherwise drops to IDLE
                if (load) begin
                    cnt_nxt   = ld_value;
                    state_nxt = (ld_value == '0) ? S_DONE : S_RUN;
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // State and count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef AU_DOWN_COUNTER_RELOAD_EN
    // Reload flag is control (reset); the reload value is data (no reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_flag <= 1'b0;
        end else begin
            reload_flag <= reload_flag_nxt;
        end
    end

    // Capture the start value of every accepted load for periodic restarts
    always_ff @(posedge clk) begin
        if (load) begin
            reload_val <= ld_value;
        end
    end
`endif

endmodule

// File: tb/tb_au_down_counter.sv
// Testbench for au_down_counter: three instances (ARCH 0, 1, 2) share stimulus
// and are compared against a behavioural model of the counting rules.
module tb_au_down_counter;

    localparam int W = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_valid;
    logic [W-1:0] ld_value;
    logic         en;
    logic         abort;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
    logic         auto_reload;
`endif

    logic         ld_ready_a [N];
    logic [W-1:0] cnt_a      [N];
    logic         busy_a     [N];
    logic         done_a     [N];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [W-1:0] m_cnt    = '0;
    logic [W-1:0] m_period = '0;
    logic         m_busy   = 1'b0;
    logic         m_done   = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            au_down_counter #(
                .WIDTH(W),
                .ARCH (g)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .ld_valid   (ld_valid),
                .ld_ready   (ld_ready_a[g]),
                .ld_value   (ld_value),
                .en         (en),
                .abort      (abort),
`ifdef AU_DOWN_COUNTER_RELOAD_EN
                .auto_reload(auto_reload),
`endif
                .cnt        (cnt_a[g]),
                .busy       (busy_a[g]),
                .done       (done_a[g])
            );
        end
    endgenerate

    // Advance one clock edge and apply the counting rules to the model
    task automatic tick();
        logic rdy;
        logic reload_on;
        rdy = !m_busy && !abort;
        reload_on = 1'b0;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
        reload_on = auto_reload;
`endif
        @(posedge clk);
        if (rst) begin
            m_cnt  = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (abort) begin
                m_busy = 1'b0;
                m_cnt  = '0;
            end else if (en) begin
                if (m_cnt == 0) begin
                    m_cnt = m_period;
                end else if (m_cnt == 1) begin
                    m_cnt  = '0;
                    m_done = 1'b1;
                    m_busy = reload_on;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (ld_valid && rdy) begin
                m_cnt    = ld_value;
                m_period = ld_value;
                m_busy   = (ld_value != 0);
                m_done   = (ld_value == 0);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 1'b0;
        ld_value = '0;
        en       = 1'b0;
        abort    = 1'b0;
`ifdef AU_DOWN_COUNTER_RELOAD_EN
        auto_reload = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #2;
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k], ld_ready_a[k]} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL reset_idle arch%0d cyc%0d cnt/busy/done/rdy got %h/%b/%b/%b want 00/0/0/1",
                             k, i, cnt_a[k], busy_a[k], done_a[k], ld_ready_a[k]);
                end
            end
            if (i < 10) tick();
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ec;
        logic         eb;
        logic         ed;
        do_reset();
        ld_valid = 1'b1;
        ld_value = 8'h05;
        en       = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ec = (c < 5) ? W'(5 - c) : 8'h00;
            eb = (c < 5);
            ed = (c == 5);
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k]} !== {ec, eb, ed}) begin
                    n_err++;
                    $display("FAIL basic arch%0d cyc%0d cnt/busy/done got %h/%b/%b want %h/%b/%b",
                             k, c, cnt_a[k], busy_a[k], done_a[k], ec, eb, ed);
                end
            end
            tick();
        end
    endtask

    task automatic test_pause_zero();
        logic [W-1:0] exp_c [6] = '{8'h03, 8'h02, 8'h02, 8'h02, 8'h01, 8'h00};
        logic         pat   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        ld_valid = 1'b1;
        ld_value = 8'h03;
        en       = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], done_a[k]} !== {exp_c[i], (i == 5)}) begin
                    n_err++;
                    $display("FAIL pause arch%0d step%0d cnt/done got %h/%b want %h/%b",
                             k, i, cnt_a[k], done_a[k], exp_c[i], (i == 5));
                end
            end
            if (i < 5) begin
                en = pat[i];
                tick();
            end
        end
        // zero load: done on the next cycle, never busy
        tick();
        ld_valid = 1'b1;
        ld_value = 8'h00;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k]} !== {8'h00, 1'b0, (i == 0)}) begin
                    n_err++;
                    $display("FAIL zero_load arch%0d cyc%0d cnt/busy/done got %h/%b/%b want 00/0/%b",
                             k, i, cnt_a[k], busy_a[k], done_a[k], (i == 0));
                end
            end
            tick();
        end
    endtask

    task automatic test_abort_ignore();
        do_reset();
        ld_valid = 1'b1;
        ld_value = 8'hFF;
        en       = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        abort = 1'b1;
        #2;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({cnt_a[k], busy_a[k], ld_ready_a[k]} !== {8'hF5, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL abort_pre arch%0d cnt/busy/rdy got %h/%b/%b want f5/1/0",
                         k, cnt_a[k], busy_a[k], ld_ready_a[k]);
            end
        end
        tick();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k]} !== {8'h00, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL abort_post arch%0d cyc%0d cnt/busy/done got %h/%b/%b want 00/0/0",
                             k, i, cnt_a[k], busy_a[k], done_a[k]);
                end
            end
            tick();
        end
        // load presented during RUN is not taken
        ld_valid = 1'b1;
        ld_value = 8'h09;
        tick();
        ld_value = 8'h07;
        #2;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (ld_ready_a[k] !== 1'b0) begin
                n_err++;
                $display("FAIL ignore_rdy arch%0d got %b want 0", k, ld_ready_a[k]);
            end
        end
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (cnt_a[k] !== 8'h08) begin
                n_err++;
                $display("FAIL ignore_cnt arch%0d got %h want 08", k, cnt_a[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ld_valid = 1'b1;
        ld_value = 8'h02;
        en       = 1'b1;
        tick();
        ld_value = 8'h04;
        tick();
        tick();
        #2;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({done_a[k], ld_ready_a[k]} !== 2'b11) begin
                n_err++;
                $display("FAIL b2b_done arch%0d done/rdy got %b/%b want 1/1", k, done_a[k], ld_ready_a[k]);
            end
        end
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k]} !== {W'(4 - i), (i < 4), (i == 4)}) begin
                    n_err++;
                    $display("FAIL b2b_second arch%0d step%0d cnt/busy/done got %h/%b/%b want %h/%b/%b",
                             k, i, cnt_a[k], busy_a[k], done_a[k], W'(4 - i), (i < 4), (i == 4));
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ld_valid = 1'b1;
        ld_value = 8'h85;
        en       = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (cnt_a[k] !== 8'h80) begin
                n_err++;
                $display("FAIL rst_mid_pre arch%0d cnt got %h want 80", k, cnt_a[k]);
            end
        end
        ld_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld_valid = 1'b0;
        #2;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({cnt_a[k], busy_a[k], done_a[k], ld_ready_a[k]} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL rst_mid arch%0d cnt/busy/done/rdy got %h/%b/%b/%b want 00/0/0/1",
                         k, cnt_a[k], busy_a[k], done_a[k], ld_ready_a[k]);
            end
        end
    endtask

`ifdef AU_DOWN_COUNTER_RELOAD_EN
    task automatic test_reload();
        do_reset();
        auto_reload = 1'b1;
        ld_valid    = 1'b1;
        ld_value    = 8'h03;
        en          = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k]} !== {W'(3 - (i % 4)), 1'b1, ((i % 4) == 3)}) begin
                    n_err++;
                    $display("FAIL reload arch%0d cyc%0d cnt/busy/done got %h/%b/%b want %h/1/%b",
                             k, i, cnt_a[k], busy_a[k], done_a[k], W'(3 - (i % 4)), ((i % 4) == 3));
                end
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({cnt_a[k], busy_a[k], done_a[k]} !== {8'h00, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reload_abort arch%0d cnt/busy/done got %h/%b/%b want 00/0/0",
                         k, cnt_a[k], busy_a[k], done_a[k]);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_value = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
            en       = ($urandom_range(0, 3) != 0);
            abort    = ($urandom_range(0, 24) == 0);
`ifdef AU_DOWN_COUNTER_RELOAD_EN
            auto_reload = ($urandom_range(0, 2) == 0);
`endif
            #2;
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if (ld_ready_a[k] !== (!m_busy && !abort)) begin
                    n_err++;
                    $display("FAIL rand_rdy arch%0d cyc%0d got %b want %b", k, i, ld_ready_a[k], (!m_busy && !abort));
                end
            end
            tick();
            for (int k = 0; k < N; k++) begin
                n_cmp++;
                if ({cnt_a[k], busy_a[k], done_a[k]} !== {m_cnt, m_busy, m_done}) begin
                    n_err++;
                    $display("FAIL rand_out arch%0d cyc%0d cnt/busy/done got %h/%b/%b want %h/%b/%b",
                             k, i, cnt_a[k], busy_a[k], done_a[k], m_cnt, m_busy, m_done);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_pause_zero();
        test_abort_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef AU_DOWN_COUNTER_RELOAD_EN
        test_reload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
